// File: rtl/sd_adc_decimator_pkg.sv
// Shared constants and types for the stereo sigma-delta decimator.
// CIC geometry is derived from the decimation exponent so every file agrees on widths.
package sd_adc_decimator_pkg;

    localparam int CIC_ORDER    = 3;
    localparam int PCM_W        = 16;
    localparam int PCM_MAX      = 32767;
    localparam int PCM_MIN      = -32768;
    localparam int SETTLE_TICKS = 3;

    typedef logic signed [PCM_W-1:0] pcm_t;

    typedef struct packed {
        pcm_t l;
        pcm_t r;
    } pcm_pair_t;

    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 1;
    endfunction

    function automatic int cic_shift(input int decim_log2);
        return CIC_ORDER * decim_log2 - PCM_W;
    endfunction

endpackage

// File: rtl/sd_adc_decimator_cic3.sv
// One channel of the decimator: input synchroniser, 3rd-order CIC and PCM scaling.
// The tick strobe from the shared counter marks the decimation instant.
module cic3_channel
    import sd_adc_decimator_pkg::*;
#(
    parameter int DECIM_LOG2 = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    input  logic tick,
    output pcm_t result,
    output logic result_stb
);

    localparam int W     = cic_width(DECIM_LOG2);
    localparam int SHIFT = cic_shift(DECIM_LOG2);

    // Mid-scale offset 2**(W-2) maps the unsigned comb range onto signed PCM.
    localparam logic signed [W:0] OFFSET = {3'b001, {(W-2){1'b0}}};
    localparam logic signed [W:0] SAT_HI = (W+1)'(PCM_MAX);
    localparam logic signed [W:0] SAT_LO = (W+1)'(PCM_MIN);

    logic [1:0]           sync_q;
    logic [W-1:0]         x_ext;
    logic [W-1:0]         integ1, integ2, integ3;
    logic [W-1:0]         integ3_prev, comb1, comb1_prev, comb2, comb2_prev, comb3;
    logic [CIC_ORDER-1:0] stb_q;
    logic signed [W:0]    centered, scaled;

    assign x_ext = {{(W-1){1'b0}}, sync_q[1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the cascaded integrators rely on this to read the previous stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            integ1 <= '0;
            integ2 <= '0;
            integ3 <= '0;
        end else begin
            sync_q <= {sync_q[0], d};
            integ1 <= integ1 + x_ext;
            integ2 <= integ2 + integ1;
            integ3 <= integ3 + integ2;
        end
    end

    // Comb stages run one per cycle after the tick; differences wrap exactly as the integrators do.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            integ3_prev <= '0;
            comb1       <= '0;
            comb1_prev  <= '0;
            comb2       <= '0;
            comb2_prev  <= '0;
            comb3       <= '0;
            stb_q       <= '0;
        end else begin
            stb_q <= {stb_q[CIC_ORDER-2:0], tick};
            if (tick) begin
                comb1       <= integ3 - integ3_prev;
                integ3_prev <= integ3;
            end
            if (stb_q[0]) begin
                comb2      <= comb1 - comb1_prev;
                comb1_prev <= comb1;
            end
            if (stb_q[1]) begin
                comb3      <= comb2 - comb2_prev;
                comb2_prev <= comb2;
            end
        end
    end

    assign result_stb = stb_q[CIC_ORDER-1];

    // comb3 spans 0..2**(W-1), so it is treated as unsigned before centring.
    always_comb begin
        centered = $signed({1'b0, comb3}) - OFFSET;
        scaled   = centered >>> SHIFT;
        if (scaled > SAT_HI) begin
            result = pcm_t'(PCM_MAX);
        end else if (scaled < SAT_LO) begin
            result = pcm_t'(PCM_MIN);
        end else begin
            result = scaled[PCM_W-1:0];
        end
    end

endmodule

// File: rtl/sd_adc_decimator.sv
// Stereo 1-bit sigma-delta receiver: two CIC channels sharing one decimation counter,
// a settle gate that drops the first results, and a one-deep valid/ready output buffer.
module sd_adc_decimator
    import sd_adc_decimator_pkg::*;
#(
    parameter int DECIM_LOG2 = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d_l,
    input  logic             d_r,
    output logic [PCM_W-1:0] q_l,
    output logic [PCM_W-1:0] q_r,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun
);

    logic [DECIM_LOG2-1:0] decim_cnt;
    logic                  tick;
    logic [1:0]            settle_cnt;
    logic                  settled;
    pcm_t                  res_l, res_r;
    logic                  stb_l, stb_r, res_stb;
    logic                  load, accept;
    pcm_pair_t             pair_q;

    assign tick = &decim_cnt;

    cic3_channel #(.DECIM_LOG2(DECIM_LOG2)) u_cic_l (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d_l),
        .tick       (tick),
        .result     (res_l),
        .result_stb (stb_l)
    );

    cic3_channel #(.DECIM_LOG2(DECIM_LOG2)) u_cic_r (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d_r),
        .tick       (tick),
        .result     (res_r),
        .result_stb (stb_r)
    );

    assign res_stb = stb_l & stb_r;
    assign settled = (settle_cnt == 2'(SETTLE_TICKS));
    assign load    = res_stb & settled;
    assign accept  = q_valid & q_ready;

    // The settle counter saturates, so only the first few results after reset are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decim_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            decim_cnt <= decim_cnt + DECIM_LOG2'(1);
            if (res_stb && !settled) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
        end
    end

    // A load wins over an accept; overrun only when a held pair is lost unread.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_q  <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                pair_q  <= '{l: res_l, r: res_r};
                q_valid <= 1'b1;
                if (q_valid && !q_ready) begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                q_valid <= 1'b0;
            end
        end
    end

    assign q_l = pair_q.l;
    assign q_r = pair_q.r;

endmodule

// File: tb/tb_sd_adc_decimator.sv
// Directed bench for sd_adc_decimator at DECIM_LOG2=8 (R=256, first pair at cycle 1027).
// Cycle numbers count rising edges since reset release; outputs are sampled on falling edges.
module tb_sd_adc_decimator;

    localparam int R      = 256;
    localparam int FIRST  = 4 * R - 1 + 4;
    localparam logic [15:0] P_MAX = 16'h7fff;
    localparam logic [15:0] P_MIN = 16'h8000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        d_l, d_r;
    logic        lvl_l = 1'b1, lvl_r = 1'b1;
    logic        tog_l_en = 1'b0, tog_r_en = 1'b0;
    logic        tog_q = 1'b0;
    logic [15:0] q_l, q_r;
    logic        q_valid, q_ready = 1'b1, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;
    always @(negedge clk) tog_q <= ~tog_q;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    assign d_l = tog_l_en ? tog_q : lvl_l;
    assign d_r = tog_r_en ? tog_q : lvl_r;

    sd_adc_decimator #(.DECIM_LOG2(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d_l     (d_l),
        .d_r     (d_r),
        .q_l     (q_l),
        .q_r     (q_r),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .overrun (overrun)
    );

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (q_l !== 16'h0)  begin n_bad++; $display("FAIL reset_q_l got %h want 0000", q_l); end
        n_cmp++; if (q_r !== 16'h0)  begin n_bad++; $display("FAIL reset_q_r got %h want 0000", q_r); end
        n_cmp++; if (q_valid !== 1'b0) begin n_bad++; $display("FAIL reset_q_valid got %b want 0", q_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_all_ones();
        int early = 0;
        lvl_l = 1'b1; lvl_r = 1'b1; tog_l_en = 1'b0; tog_r_en = 1'b0; q_ready = 1'b1;
        apply_reset();
        while (cyc < FIRST - 1) begin
            @(negedge clk);
            if (cyc < FIRST && q_valid !== 1'b0) early++;
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL ones_settle early q_valid seen %0d times want 0", early); end
        go_to(FIRST);
        n_cmp++; if (q_valid !== 1'b1) begin n_bad++; $display("FAIL ones_first_valid at cyc %0d got %b want 1", cyc, q_valid); end
        n_cmp++; if (q_l !== P_MAX) begin n_bad++; $display("FAIL ones_q_l got %h want %h", q_l, P_MAX); end
        n_cmp++; if (q_r !== P_MAX) begin n_bad++; $display("FAIL ones_q_r got %h want %h", q_r, P_MAX); end
        go_to(FIRST + 1);
        n_cmp++; if (q_valid !== 1'b0) begin n_bad++; $display("FAIL ones_pulse_width got %b want 0", q_valid); end
        go_to(FIRST + R - 1);
        n_cmp++; if (q_valid !== 1'b0) begin n_bad++; $display("FAIL ones_gap got %b want 0", q_valid); end
        go_to(FIRST + R);
        n_cmp++; if (q_valid !== 1'b1 || q_l !== P_MAX || q_r !== P_MAX)
            begin n_bad++; $display("FAIL ones_second_pair got v=%b l=%h r=%h want v=1 l=%h r=%h", q_valid, q_l, q_r, P_MAX, P_MAX); end
    endtask

    task automatic test_polarity();
        lvl_l = 1'b0; lvl_r = 1'b1; tog_l_en = 1'b0; tog_r_en = 1'b0; q_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            go_to(FIRST + k * R);
            n_cmp++; if (q_valid !== 1'b1 || q_l !== P_MIN || q_r !== P_MAX)
                begin n_bad++; $display("FAIL polarity_pair%0d got v=%b l=%h r=%h want v=1 l=%h r=%h", k, q_valid, q_l, q_r, P_MIN, P_MAX); end
        end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL polarity_overrun got %b want 0", overrun); end
    endtask

    task automatic test_toggle();
        logic signed [15:0] r_prev;
        lvl_r = 1'b1; tog_l_en = 1'b1; tog_r_en = 1'b0; q_ready = 1'b1;
        apply_reset();
        go_to(512);
        tog_r_en = 1'b1;
        r_prev = 16'sh7fff;
        for (int k = 0; k < 5; k++) begin
            go_to(FIRST + k * R);
            n_cmp++; if (q_valid !== 1'b1 || q_l !== 16'h0)
                begin n_bad++; $display("FAIL toggle_left_pair%0d got v=%b l=%h want v=1 l=0000", k, q_valid, q_l); end
            if (k == 0) begin
                n_cmp++; if (!($signed(q_r) > 0 && $signed(q_r) < 32767))
                    begin n_bad++; $display("FAIL toggle_right_first got %0d want in (0,32767)", $signed(q_r)); end
            end else if (k == 1) begin
                n_cmp++; if (!($signed(q_r) >= 0 && $signed(q_r) <= r_prev))
                    begin n_bad++; $display("FAIL toggle_right_step got %0d want in [0,%0d]", $signed(q_r), r_prev); end
            end else begin
                n_cmp++; if (q_r !== 16'h0)
                    begin n_bad++; $display("FAIL toggle_right_pair%0d got %h want 0000", k, q_r); end
            end
            r_prev = $signed(q_r);
        end
        tog_l_en = 1'b0; tog_r_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        lvl_l = 1'b1; lvl_r = 1'b1; q_ready = 1'b0;
        apply_reset();
        go_to(FIRST + R - 1);
        q_ready = 1'b1;
        go_to(FIRST + R);
        q_ready = 1'b0;
        n_cmp++; if (q_valid !== 1'b1 || q_l !== P_MAX)
            begin n_bad++; $display("FAIL b2b_load got v=%b l=%h want v=1 l=%h", q_valid, q_l, P_MAX); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        go_to(FIRST + R + 1);
        n_cmp++; if (q_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_hold got %b want 1", q_valid); end
    endtask

    task automatic test_overrun();
        int drops = 0;
        lvl_l = 1'b1; lvl_r = 1'b1; q_ready = 1'b0;
        apply_reset();
        go_to(FIRST);
        lvl_l = 1'b0; lvl_r = 1'b0;
        while (cyc < FIRST + 3 * R) begin
            @(negedge clk);
            if (q_valid !== 1'b1) drops++;
            if (cyc == FIRST + R - 1) begin
                n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_before got %b want 0", overrun); end
            end
            if (cyc == FIRST + R) begin
                n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", overrun); end
            end
        end
        n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL ovr_valid_held dropped %0d cycles want 0", drops); end
        n_cmp++; if (!($signed(q_l) < 0) || q_l !== q_r)
            begin n_bad++; $display("FAIL ovr_newest got l=%h r=%h want equal and negative", q_l, q_r); end
        q_ready = 1'b1;
        go_to(FIRST + 3 * R + 2);
        n_cmp++; if (q_valid !== 1'b0 || overrun !== 1'b1)
            begin n_bad++; $display("FAIL ovr_sticky got v=%b o=%b want v=0 o=1", q_valid, overrun); end
        q_ready = 1'b0;
        go_to(FIRST + 4 * R);
        n_cmp++; if (q_valid !== 1'b1 || overrun !== 1'b1)
            begin n_bad++; $display("FAIL ovr_reload got v=%b o=%b want v=1 o=1", q_valid, overrun); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (q_valid !== 1'b0 || overrun !== 1'b0 || q_l !== 16'h0 || q_r !== 16'h0)
            begin n_bad++; $display("FAIL midreset_async got v=%b o=%b l=%h r=%h want all 0", q_valid, overrun, q_l, q_r); end
        lvl_l = 1'b1; lvl_r = 1'b1; q_ready = 1'b1;
        apply_reset();
        go_to(FIRST - 1);
        n_cmp++; if (q_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_early got %b want 0", q_valid); end
        go_to(FIRST);
        n_cmp++; if (q_valid !== 1'b1 || q_l !== P_MAX || q_r !== P_MAX || overrun !== 1'b0)
            begin n_bad++; $display("FAIL midreset_first got v=%b l=%h r=%h o=%b want v=1 l=%h r=%h o=0", q_valid, q_l, q_r, overrun, P_MAX, P_MAX); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_polarity();
        test_toggle();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
